// File: rtl/dsp_mac_seq_pkg.sv
// Shared definitions for the DSP48A1 MAC sequencer: FSM states and OPMODE codes.
package dsp_mac_seq_pkg;

    localparam int LAT  = 3;
    localparam int LENW = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // OPMODE[3:2] = Z mux, OPMODE[1:0] = X mux; upper nibble always zero.
    localparam logic [7:0] OP_FIRST = 8'h01;  // X=M, Z=0
    localparam logic [7:0] OP_ACC   = 8'h09;  // X=M, Z=P
    localparam logic [7:0] OP_HOLD  = 8'h08;  // X=0, Z=P
    localparam logic [7:0] OP_CLR   = 8'h00;  // X=0, Z=0

endpackage

// File: rtl/dsp_mac_seq.sv
// Operand sequencer and result collector for one DSP48A1 slice used as a
// multiply-accumulate engine. A/B are registered once; the opcode is
// registered twice so it meets the product at the slice M stage.
module dsp_mac_seq
    import dsp_mac_seq_pkg::*;
#(
    parameter int LAT  = dsp_mac_seq_pkg::LAT,
    parameter int LENW = dsp_mac_seq_pkg::LENW
) (
    input  logic            clk,
    input  logic            RST,
    input  logic            start,
    input  logic [LENW-1:0] len,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [17:0]     in_a,
    input  logic [17:0]     in_b,
    output logic [17:0]     A,
    output logic [17:0]     B,
    output logic [7:0]      OPMODE,
    input  logic [47:0]     P,
    input  logic            CARRYOUT,
    output logic            busy,
    output logic [47:0]     res,
    output logic            res_carry,
    output logic            res_valid
);

    localparam int DW = $clog2(LAT + 2) + 1;

    state_t          state, state_next;
    logic [LENW-1:0] terms;
    logic            first;
    logic [DW-1:0]   drain_cnt;
    logic [7:0]      op_next, op_d;
    logic            hs;

    // Next-state, opcode selection and handshake decode.
    always_comb begin
        state_next = state;
        op_next    = OP_HOLD;
        hs         = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        state_next = DRAIN;
                        op_next    = OP_CLR;
                    end else begin
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (in_valid) begin
                    hs      = 1'b1;
                    op_next = first ? OP_FIRST : OP_ACC;
                    if (terms == LENW'(1)) state_next = DRAIN;
                end
            end
            // Waiting LAT+1 counts past entry keeps P stable for a full cycle before capture.
            DRAIN: begin
                if (drain_cnt == DW'(LAT + 1)) state_next = DONE;
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign in_ready  = (state == RUN);
    assign busy      = (state != IDLE);
    assign res_valid = (state == DONE);

    // State register, term/drain counters, operand and opcode pipeline, result capture.
    always_ff @(posedge clk) begin
        if (RST) begin
            state     <= IDLE;
            terms     <= '0;
            first     <= 1'b0;
            drain_cnt <= '0;
            A         <= '0;
            B         <= '0;
            op_d      <= '0;
            OPMODE    <= '0;
            res       <= '0;
            res_carry <= 1'b0;
        end else begin
            state  <= state_next;
            op_d   <= op_next;
            OPMODE <= op_d;
            if (state == IDLE && start) begin
                terms <= len;
                first <= 1'b1;
            end
            if (hs) begin
                terms <= terms - LENW'(1);
                first <= 1'b0;
                A     <= in_a;
                B     <= in_b;
            end
            if (state == DRAIN) drain_cnt <= drain_cnt + DW'(1);
            else                drain_cnt <= '0;
            if (state == DRAIN && state_next == DONE) begin
                res       <= P;
                res_carry <= CARRYOUT;
            end
        end
    end

endmodule

// File: tb/tb_dsp_mac_seq.sv
// Scoreboard bench for dsp_mac_seq with a behavioural DSP48A1 slice beside it.
module tb_dsp_mac_seq;
    import dsp_mac_seq_pkg::*;

    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic [15:0] len = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [17:0] in_a = '0, in_b = '0;
    logic [17:0] A, B;
    logic [7:0]  OPMODE;
    logic [47:0] P;
    logic        CARRYOUT;
    logic        busy;
    logic [47:0] res;
    logic        res_carry;
    logic        res_valid;

    always #5 clk = ~clk;

    dsp_mac_seq #(.LAT(3), .LENW(16)) dut (
        .clk(clk), .RST(RST), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .A(A), .B(B), .OPMODE(OPMODE), .P(P), .CARRYOUT(CARRYOUT),
        .busy(busy), .res(res), .res_carry(res_carry), .res_valid(res_valid)
    );

    // Behavioural slice: A1/B1/OPMODE regs, M reg, P reg with 48-bit post-adder.
    logic signed [17:0] a1, b1;
    logic        [7:0]  opm_r;
    logic signed [47:0] m;
    logic        [47:0] xv, zv;
    assign xv = (opm_r[1:0] == 2'b01) ? m : '0;
    assign zv = (opm_r[3:2] == 2'b10) ? P : '0;
    always @(posedge clk) begin
        if (RST) begin
            a1 <= '0; b1 <= '0; opm_r <= '0; m <= '0; P <= '0; CARRYOUT <= 1'b0;
        end else begin
            a1 <= A; b1 <= B; opm_r <= OPMODE;
            m <= a1 * b1;
            {CARRYOUT, P} <= {1'b0, zv} + {1'b0, xv};
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [47:0] res; int cyc; } exp_t;
    exp_t exp_q[$];

    int n_pass = 0, n_tot = 0;
    logic [17:0] ja[0:15], jb[0:15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tot++;
        if (act !== req) $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        else n_pass++;
    endtask

    function automatic logic [47:0] ref_dot(input int n);
        longint acc = 0;
        logic [63:0] t;
        for (int i = 0; i < n; i++)
            acc += longint'($signed(ja[i])) * longint'($signed(jb[i]));
        t = acc;
        return t[47:0];
    endfunction

    task automatic issue_pair(input logic [17:0] a, input logic [17:0] b, output int hs_cyc);
        logic rdy;
        int guard = 0;
        in_valid = 1'b1; in_a = a; in_b = b;
        do begin
            @(negedge clk); rdy = in_ready;
            @(posedge clk); #1; guard++;
        end while (!rdy && guard < 20);
        if (!rdy) chk("handshake_timeout", {63'd0, rdy}, 64'd1);
        hs_cyc = cyc;
        in_valid = 1'b0;
    endtask

    // bubbles < 0 picks 0 or 1 idle cycles per pair at random.
    task automatic run_job(input int n, input int bubbles, input bit glitch);
        int hc = 0;
        int nb;
        start = 1'b1; len = 16'(n);
        @(posedge clk); #1;
        start = 1'b0; len = 16'($urandom);
        if (n == 0) begin
            exp_q.push_back('{res: 48'd0, cyc: cyc});
            return;
        end
        for (int i = 0; i < n; i++) begin
            if (i == 1 && glitch) begin
                in_valid = 1'b0; start = 1'b1; len = 16'd0;
                @(posedge clk); #1;
                start = 1'b0;
            end
            if (i > 0) begin
                nb = (bubbles < 0) ? int'($urandom_range(0, 1)) : bubbles;
                in_valid = 1'b0; in_a = 18'($urandom); in_b = 18'($urandom);
                for (int k = 0; k < nb; k++) begin
                    @(posedge clk); #1;
                    if (k == 1) begin
                        chk("bubble_opmode", {56'd0, OPMODE}, {56'd0, OP_HOLD});
                        chk("bubble_a_hold", {46'd0, A}, {46'd0, ja[i-1]});
                    end
                end
            end
            issue_pair(ja[i], jb[i], hc);
        end
        exp_q.push_back('{res: ref_dot(n), cyc: hc});
    endtask

    task automatic wait_idle();
        int guard = 0;
        while ((exp_q.size() != 0 || busy) && guard < 60) begin
            @(posedge clk); #1; guard++;
        end
        chk("job_completion", {63'd0, (exp_q.size() == 0 && !busy)}, 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hc;
        int n;
        logic prev_v = 1'b0;
        exp_t e;

        fork
            forever begin
                @(negedge clk);
                if (RST) begin
                    prev_v = 1'b0;
                end else begin
                    if (prev_v) chk("busy_fall", {63'd0, busy}, 64'd0);
                    if (res_valid) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_res_valid", {63'd0, res_valid}, 64'd0);
                        end else begin
                            e = exp_q.pop_front();
                            chk("res", {16'd0, res}, {16'd0, e.res});
                            chk("res_carry", {63'd0, res_carry}, 64'd0);
                            chk("res_latency", 64'(cyc), 64'(e.cyc + LAT + 2));
                            chk("busy_at_valid", {63'd0, busy}, 64'd1);
                        end
                    end
                    prev_v = res_valid;
                end
            end
        join_none

        // Reset with random inputs toggling.
        RST = 1'b1;
        repeat (2) begin
            start = 1'($urandom); in_valid = 1'($urandom);
            in_a = 18'($urandom); in_b = 18'($urandom); len = 16'($urandom);
            @(posedge clk); #1;
        end
        chk("rst_A", {46'd0, A}, 64'd0);
        chk("rst_B", {46'd0, B}, 64'd0);
        chk("rst_OPMODE", {56'd0, OPMODE}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_res_valid", {63'd0, res_valid}, 64'd0);
        chk("rst_res", {16'd0, res}, 64'd0);
        start = 1'b0; in_valid = 1'b0;
        RST = 1'b0;
        @(posedge clk); #1;

        // Directed: (20,10),(5,6),(3,7) back-to-back -> 0xFB.
        ja[0] = 18'd20; jb[0] = 18'd10;
        ja[1] = 18'd5;  jb[1] = 18'd6;
        ja[2] = 18'd3;  jb[2] = 18'd7;
        chk("ref_fb", {16'd0, ref_dot(3)}, 64'hFB);
        run_job(3, 0, 1'b0);
        wait_idle();
        // Same job with two-cycle bubbles.
        run_job(3, 2, 1'b0);
        wait_idle();
        // (-4,5),(3,3) -> -11.
        ja[0] = 18'h3FFFC; jb[0] = 18'd5;
        ja[1] = 18'd3;     jb[1] = 18'd3;
        run_job(2, 0, 1'b0);
        wait_idle();
        // len = 0.
        run_job(0, 0, 1'b0);
        wait_idle();
        // start pulsed mid-RUN must be ignored.
        ja[0] = 18'd20; jb[0] = 18'd10;
        ja[1] = 18'd5;  jb[1] = 18'd6;
        ja[2] = 18'd3;  jb[2] = 18'd7;
        run_job(3, 0, 1'b1);
        wait_idle();

        // Abort a len=4 job with RST after two pairs.
        start = 1'b1; len = 16'd4;
        @(posedge clk); #1;
        start = 1'b0;
        issue_pair(18'd100, 18'd100, hc);
        issue_pair(18'd50, 18'd50, hc);
        RST = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_in_ready", {63'd0, in_ready}, 64'd0);
        chk("abort_OPMODE", {56'd0, OPMODE}, 64'd0);
        RST = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        chk("abort_no_result", 64'(exp_q.size()), 64'd0);
        ja[0] = 18'd7; jb[0] = 18'd8;
        run_job(1, 0, 1'b0);
        wait_idle();

        // Randomized jobs, started in the IDLE cycle right after DONE.
        for (int j = 0; j < 10; j++) begin
            n = $urandom_range(0, 9);
            for (int i = 0; i < n; i++) begin
                ja[i] = 18'($urandom); jb[i] = 18'($urandom);
            end
            run_job(n, -1, 1'b0);
            wait_idle();
        end

        repeat (3) begin @(posedge clk); #1; end
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
